// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package hazard_unit_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EXE = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

endpackage

// File: rtl/hazard_unit_fwd_match.sv
// Per-source forward select and stall request (EXE > MEM > WB priority).
// Latency: purely combinational, zero cycles.
// Backpressure: stallReq asks the top to hold; select is 0 while stallReq is high.
// Option: HAZARD_WB_FWD_EN forwards WB matches (select 3) instead of stalling.
module hazard_fwd_match
  import hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  useRs,
  input  logic [REG_ADDR_W-1:0] erd,
  input  logic [REG_ADDR_W-1:0] mrd,
  input  logic [REG_ADDR_W-1:0] wrd,
  input  logic                  ewreg,
  input  logic                  mwreg,
  input  logic                  wwreg,
  input  logic                  em2reg,
  output logic [1:0]            sel,
  output logic                  stallReq
);

  // Pick the youngest producing stage; r0 is never forwarded.
  always_comb begin
    sel      = FWD_REG;
    stallReq = 1'b0;
    if (useRs && (rs != '0)) begin
      if (ewreg && (erd == rs)) begin
        // A load in EXE has no data yet: read the regfile and ask for a bubble.
        if (em2reg) stallReq = 1'b1;
        else        sel      = FWD_EXE;
      end else if (mwreg && (mrd == rs)) begin
        sel = FWD_MEM;
      end else if (wwreg && (wrd == rs)) begin
`ifdef HAZARD_WB_FWD_EN
        sel = FWD_WB;
`else
        stallReq = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use / multi-cycle stalls, IF flush.
// Latency: all controls combinational (zero cycles); mdBusy and stallCnt registered.
// Backpressure: holds PC/IFID during MD_WAIT or a one-cycle load-use bubble; flush yields to stalls.
// Option: HAZARD_WB_FWD_EN enables WB-stage forwarding (select 3).
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  useRs1,
  input  logic                  useRs2,
  input  logic [REG_ADDR_W-1:0] erd,
  input  logic [REG_ADDR_W-1:0] mrd,
  input  logic [REG_ADDR_W-1:0] wrd,
  input  logic                  ewreg,
  input  logic                  mwreg,
  input  logic                  wwreg,
  input  logic                  em2reg,
  input  logic                  brTaken,
  input  logic                  mdStart,
  input  logic                  mdDone,
  output logic [1:0]            qaSel,
  output logic [1:0]            qbSel,
  output logic                  pcStall,
  output logic                  ifidStall,
  output logic                  instNop,
  output logic                  ifFlush,
  output logic                  mdBusy,
  output logic [CNT_W-1:0]      stallCnt
);

  state_t     state;
  logic       luPrev;
  logic [1:0] selA, selB;
  logic       reqA, reqB;
  logic       mdHold;
  logic       luStall;

  hazard_fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_a (
    .rs(rs1), .useRs(useRs1), .erd(erd), .mrd(mrd), .wrd(wrd),
    .ewreg(ewreg), .mwreg(mwreg), .wwreg(wwreg), .em2reg(em2reg),
    .sel(selA), .stallReq(reqA)
  );

  hazard_fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_b (
    .rs(rs2), .useRs(useRs2), .erd(erd), .mrd(mrd), .wrd(wrd),
    .ewreg(ewreg), .mwreg(mwreg), .wwreg(wwreg), .em2reg(em2reg),
    .sel(selB), .stallReq(reqB)
  );

  // Stall priority: multi-cycle wait first, then a single load-use bubble (never two in a row), then flush.
  always_comb begin
    mdHold    = (state == MD_WAIT) && !mdDone;
    luStall   = (reqA || reqB) && !luPrev && !mdHold;
    qaSel     = selA;
    qbSel     = selB;
    pcStall   = mdHold || luStall;
    ifidStall = mdHold || luStall;
    instNop   = luStall;
    ifFlush   = brTaken && !mdHold && !luStall;
  end

  // RUN/MD_WAIT sequencing with mdBusy registered alongside the state.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state  <= RUN;
      mdBusy <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mdStart && !luStall) begin
            state  <= MD_WAIT;
            mdBusy <= 1'b1;
          end
        end
        MD_WAIT: begin
          if (mdDone) begin
            state  <= RUN;
            mdBusy <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          mdBusy <= 1'b0;
        end
      endcase
    end
  end

  // Remember last cycle's bubble and count stall cycles, saturating at all-ones.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      luPrev   <= 1'b0;
      stallCnt <= '0;
    end else begin
      luPrev <= luStall;
      if (pcStall && (stallCnt != {CNT_W{1'b1}})) stallCnt <= stallCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int AW = 5;
  localparam int CW = 3;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic T = 1'b1;

  logic          clk = 1'b0;
  logic          rstN;
  logic [AW-1:0] rs1, rs2, erd, mrd, wrd;
  logic          useRs1, useRs2, ewreg, mwreg, wwreg, em2reg, brTaken, mdStart, mdDone;
  logic [1:0]    qaSel, qbSel;
  logic          pcStall, ifidStall, instNop, ifFlush, mdBusy;
  logic [CW-1:0] stallCnt;

  always #5 clk = ~clk;

  hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rstN(rstN),
    .rs1(rs1), .rs2(rs2), .useRs1(useRs1), .useRs2(useRs2),
    .erd(erd), .mrd(mrd), .wrd(wrd),
    .ewreg(ewreg), .mwreg(mwreg), .wwreg(wwreg), .em2reg(em2reg),
    .brTaken(brTaken), .mdStart(mdStart), .mdDone(mdDone),
    .qaSel(qaSel), .qbSel(qbSel), .pcStall(pcStall), .ifidStall(ifidStall),
    .instNop(instNop), .ifFlush(ifFlush), .mdBusy(mdBusy), .stallCnt(stallCnt)
  );

  typedef struct {
    logic [AW-1:0] rs1, rs2, erd, mrd, wrd;
    logic          u1, u2, ew, mw, ww, ld, br, ms, md;
    logic [1:0]    xqa, xqb;
    logic          xpc, xif, xnop, xfl, xbusy;
  } vec_t;

  int            checks = 0;
  int            failures = 0;
  vec_t          sb[$];
  vec_t          tbl[$];
  logic [CW-1:0] expCnt = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    rs1 = v.rs1; rs2 = v.rs2; useRs1 = v.u1; useRs2 = v.u2;
    erd = v.erd; mrd = v.mrd; wrd = v.wrd;
    ewreg = v.ew; mwreg = v.mw; wwreg = v.ww; em2reg = v.ld;
    brTaken = v.br; mdStart = v.ms; mdDone = v.md;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, ".qaSel"},     int'(qaSel),     int'(e.xqa));
    chk({tag, ".qbSel"},     int'(qbSel),     int'(e.xqb));
    chk({tag, ".pcStall"},   int'(pcStall),   int'(e.xpc));
    chk({tag, ".ifidStall"}, int'(ifidStall), int'(e.xif));
    chk({tag, ".instNop"},   int'(instNop),   int'(e.xnop));
    chk({tag, ".ifFlush"},   int'(ifFlush),   int'(e.xfl));
    chk({tag, ".mdBusy"},    int'(mdBusy),    int'(e.xbusy));
    chk({tag, ".stallCnt"},  int'(stallCnt),  int'(expCnt));
    if (e.xpc && (expCnt != CNT_MAX)) expCnt = expCnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Pulse reset away from clock edges and check the asynchronous reset values.
  task automatic do_reset(input string tag);
    rs1 = '0; rs2 = '0; erd = '0; mrd = '0; wrd = '0;
    useRs1 = 1'b0; useRs2 = 1'b0; ewreg = 1'b0; mwreg = 1'b0; wwreg = 1'b0;
    em2reg = 1'b0; brTaken = 1'b0; mdStart = 1'b0; mdDone = 1'b0;
    rstN = 1'b0;
    #2;
    chk({tag, ".mdBusy"},   int'(mdBusy),   0);
    chk({tag, ".stallCnt"}, int'(stallCnt), 0);
    chk({tag, ".pcStall"},  int'(pcStall),  0);
    chk({tag, ".instNop"},  int'(instNop),  0);
    #1;
    rstN = 1'b1;
    expCnt = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    vec_t wait_v;
    vec_t idle_v;

    // Main table: forwarding, load-use, priority, branch flush, multi-cycle wait.
    tbl.push_back('{default: '0});
    tbl.push_back('{rs1: 5'd5, u1: T, erd: 5'd5, ew: T, xqa: 2'd1, default: '0});
    tbl.push_back('{rs2: 5'd7, u2: T, erd: 5'd7, ew: T, ld: T,
                    xpc: T, xif: T, xnop: T, default: '0});
    tbl.push_back('{rs2: 5'd7, u2: T, mrd: 5'd7, mw: T, xqb: 2'd2, default: '0});
    tbl.push_back('{u1: T, ew: T, mw: T, ww: T, default: '0});
    tbl.push_back('{rs1: 5'd3, u1: T, mrd: 5'd3, wrd: 5'd3, mw: T, ww: T, xqa: 2'd2, default: '0});
`ifdef HAZARD_WB_FWD_EN
    tbl.push_back('{rs1: 5'd3, u1: T, wrd: 5'd3, ww: T, xqa: 2'd3, default: '0});
    tbl.push_back('{rs1: 5'd3, u1: T, wrd: 5'd3, ww: T, xqa: 2'd3, default: '0});
`else
    tbl.push_back('{rs1: 5'd3, u1: T, wrd: 5'd3, ww: T, xpc: T, xif: T, xnop: T, default: '0});
    tbl.push_back('{rs1: 5'd3, u1: T, wrd: 5'd3, ww: T, default: '0});
`endif
    tbl.push_back('{rs1: 5'd9, rs2: 5'd9, u1: T, u2: T, erd: 5'd9, mrd: 5'd9, wrd: 5'd9,
                    ew: T, mw: T, ww: T, xqa: 2'd1, xqb: 2'd1, default: '0});
    tbl.push_back('{rs1: 5'd4, rs2: 5'd4, u2: T, erd: 5'd4, mrd: 5'd4, ew: 1'b0, mw: T,
                    xqb: 2'd2, default: '0});
    tbl.push_back('{rs1: 5'd6, u1: T, erd: 5'd6, ew: T, ld: T, br: T,
                    xpc: T, xif: T, xnop: T, default: '0});
    tbl.push_back('{rs1: 5'd6, u1: T, mrd: 5'd6, mw: T, br: T, xqa: 2'd2, xfl: T, default: '0});
    tbl.push_back('{ms: T, default: '0});
    tbl.push_back('{xpc: T, xif: T, xbusy: T, default: '0});
    tbl.push_back('{rs1: 5'd6, u1: T, erd: 5'd6, ew: T, ld: T,
                    xpc: T, xif: T, xbusy: T, default: '0});
    tbl.push_back('{br: T, xpc: T, xif: T, xbusy: T, default: '0});
    tbl.push_back('{ms: T, xpc: T, xif: T, xbusy: T, default: '0});
    tbl.push_back('{md: T, xbusy: T, default: '0});
    tbl.push_back('{md: T, default: '0});
    tbl.push_back('{default: '0});

    rstN = 1'b0;
    #2;
    do_reset("reset0");

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Multi-cycle wait from a clean counter: four wait cycles give stallCnt=4.
    do_reset("reset1");
    wait_v = '{xpc: T, xif: T, xbusy: T, default: '0};
    idle_v = '{default: '0};
    v = '{ms: T, default: '0};
    run_vec(v, "md_start");
    for (int i = 0; i < 4; i++) run_vec(wait_v, $sformatf("md_wait%0d", i));
    chk("md_stallcnt_4", int'(stallCnt), 4);

    // Keep waiting until the counter pins at its maximum.
    for (int i = 0; i < 4; i++) run_vec(wait_v, $sformatf("sat_wait%0d", i));
    chk("stallcnt_saturated", int'(stallCnt), 7);

    // Reset while still waiting abandons the operation without any mdDone.
    do_reset("reset_midwait");
    run_vec(idle_v, "after_reset_run");
    v = '{rs2: 5'd7, u2: T, erd: 5'd7, ew: T, ld: T, xpc: T, xif: T, xnop: T, default: '0};
    run_vec(v, "after_reset_lu");
    chk("after_reset_cnt1", int'(stallCnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Clock and reset SHALL be: clk  input  1  rising-edge clock; rstN  input  1  asynchronous, active-low reset.
REQ-002 Parameters SHALL be: REG_ADDR_W, default 5, register-index width; CNT_W, default 16, stall-counter width.
REQ-003 Ports SHALL be (name  direction  width  meaning):
- rs1, rs2  in  REG_ADDR_W  ID source registers
- useRs1, useRs2  in  1  ID instruction reads rs1 / rs2
- erd, mrd, wrd  in  REG_ADDR_W  EXE / MEM / WB destinations
- ewreg, mwreg, wwreg  in  1  EXE / MEM / WB write-back flags
- em2reg  in  1  EXE instruction is a load
- brTaken  in  1  ID branch or jump resolved taken
- mdStart  in  1  ID instruction is multi-cycle
- mdDone  in  1  multi-cycle unit completion pulse
- qaSel, qbSel  out  2  forward select: 0 regfile, 1 EXE, 2 MEM, 3 WB
- pcStall, ifidStall  out  1  hold PC / IFID
- instNop  out  1  inject bubble into IDEXE
- ifFlush  out  1  squash IF instruction
- mdBusy  out  1  FSM in MD_WAIT
- stallCnt  out  CNT_W  saturating count of stall cycles

Function
REQ-004 FSM states SHALL be RUN and MD_WAIT only.
REQ-005 Transition RUN->MD_WAIT SHALL occur when mdStart=1 and no load-use stall is active in that cycle.
REQ-006 Transition MD_WAIT->RUN SHALL occur on the cycle after mdDone=1; mdDone SHALL be ignored in RUN.
REQ-007 While in MD_WAIT with mdDone=0: pcStall=1, ifidStall=1, instNop=0, ifFlush=0, mdBusy=1.
- The same outputs SHALL be deasserted combinationally in the cycle mdDone=1.
REQ-008 Forward match for source s (rs1 or rs2) at stage X SHALL require all of:
- useRsN=1
- s!=0
- Xwreg=1
- Xrd==s
REQ-009 Match priority SHALL be EXE>MEM>WB; qaSel/qbSel SHALL be 0 when no stage matches.
REQ-010 A load-use stall SHALL be raised when an EXE match exists with em2reg=1, giving:
- pcStall=1, ifidStall=1, instNop=1
- the corresponding select forced to 0
REQ-011 Load-use stall SHALL last exactly one cycle per occurrence; a MEM-stage load match SHALL forward with select 2 and no stall.
REQ-012 ifFlush SHALL equal brTaken only when neither MD_WAIT nor a load-use stall is active; otherwise ifFlush=0 and the branch is re-evaluated.
REQ-013 Priority SHALL be: MD_WAIT stall > load-use stall > flush.
REQ-014 stallCnt SHALL increment by 1 on each cycle pcStall=1 and saturate at 2^CNT_W-1 with no wrap.
REQ-015 All outputs except stallCnt and mdBusy SHALL be combinational from inputs and state; zero-latency.

Reset
REQ-016 On rstN=0, asynchronously: state=RUN, stallCnt=0, mdBusy=0.
- Stall outputs SHALL take their RUN-state combinational values.
REQ-017 Reset asserted in MD_WAIT SHALL abandon the pending operation; no mdDone is required after release.

Configuration
REQ-018 Macro HAZARD_WB_FWD_EN defined: WB matches SHALL forward with select 3.
REQ-019 Macro HAZARD_WB_FWD_EN undefined: select 3 SHALL never be driven.
- A WB-only match SHALL raise a one-cycle stall identical to REQ-010.

Structure
REQ-020 The shared package SHALL hold:
- state enumeration (RUN, MD_WAIT)
- forward-select constants FWD_REG=0, FWD_EXE=1, FWD_MEM=2, FWD_WB=3
REQ-021 One sub-module, hazard_fwd_match, SHALL compute the per-source select and stall request; it SHALL be instantiated twice.

Verification
REQ-022 The bench SHALL cover:
- rs1=5, useRs1=1, erd=5, ewreg=1, em2reg=0 -> qaSel=1, no stall.
- rs2=7, erd=7, ewreg=1, em2reg=1 -> pcStall=ifidStall=instNop=1 for one cycle, qbSel=0; stallCnt 0->1.
- rs1=0 with erd=mrd=wrd=0, all wreg=1 -> qaSel=0.
- rs1=3, mrd=3, wrd=3, mwreg=wwreg=1 -> qaSel=2; WB-only match gives 3 with macro, one-cycle stall without.
- mdStart=1 in RUN; mdDone after 4 cycles -> mdBusy high 4 cycles, stallCnt=4; reset mid-wait -> state RUN, stallCnt=0.
- brTaken=1 with load-use stall -> ifFlush=0; brTaken=1 next cycle, no stall -> ifFlush=1.
